fm_axil_reg_slave: RTL and testbench

AXI4-Lite slave register bank for the fast-monitor (fm) user-logic block. It is the responder on the AXI interface that the master VIP drives in the fm validation bench. It decodes single-beat reads and writes into a small bank of 32-bit registers and exports the read/write control registers to fm logic. It also returns an ID word and a live status word on read.

---
 rtl/fm_axil_reg_slave.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_fm_axil_reg_slave.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// fm_axil_reg_slave
//
// AXI4-Lite slave register bank for the fast-monitor (fm) user logic.
// Single-beat reads and writes are decoded into NUM_REGS 32-bit words:
//   index 0              : ID word (read-only, ID_VALUE)
//   index 1              : live status word (read-only, status_in sampled
//                          at the AR handshake)
//   index 2..NUM_REGS-1  : control registers (read/write, byte strobes)
//
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   s_axi_aw*             write-address channel (awaddr, awvalid, awready)
//   s_axi_w*              write-data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*              write-response channel (bresp, bvalid, bready)
//   s_axi_ar*             read-address channel (araddr, arvalid, arready)
//   s_axi_r*              read-data channel (rdata, rresp, rvalid, rready)
//   status_in             live status word returned at index 1
//   ctrl_regs             flattened register image, slices 0 and 1 read as 0
//   wr_pulse              one-cycle strobe per accepted control write
//
// Build option:
//   FM_AXIL_DECERR_EN     when defined, out-of-range accesses answer DECERR;
//                         otherwise they answer OKAY (writes dropped, reads 0).
//
// All outputs come straight from flops. Handshake readies are registered
// from the next FSM state so they are low while reset is applied and rise
// on the first edge with aresetn high.
// -----------------------------------------------------------------------------
module fm_axil_reg_slave #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = 32'hF0A1_0001
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic [31:0]              status_in,
  output logic [32*NUM_REGS-1:0]   ctrl_regs,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef FM_AXIL_DECERR_EN
  localparam logic [1:0] RESP_OOR    = 2'b11;
`else
  localparam logic [1:0] RESP_OOR    = 2'b00;
`endif

  // Byte offset bits carry no meaning for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic in_range(input logic [IW-1:0] idx);
    return (32'(idx) < 32'(NUM_REGS));
  endfunction

  function automatic logic is_ctrl(input logic [IW-1:0] idx);
    return in_range(idx) && (32'(idx) >= 32'd2);
  endfunction

  function automatic logic [1:0] wr_resp(input logic [IW-1:0] idx);
    if (!in_range(idx))
      return RESP_OOR;
    else if (!is_ctrl(idx))
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

  // ---------------------------------------------------------------------------
  // Write channel FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_WAIT_D = 2'd1,
    W_WAIT_A = 2'd2,
    W_RESP   = 2'd3
  } wstate_t;

  wstate_t wstate, wstate_nxt;
  logic    aw_hs, w_hs, commit;
  logic    awready_nxt, wready_nxt, bvalid_nxt;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;

  always_ff @(posedge aclk) begin
    if (!aresetn)
      wstate <= W_IDLE;
    else
      wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs)
          wstate_nxt = W_RESP;
        else if (aw_hs)
          wstate_nxt = W_WAIT_D;
        else if (w_hs)
          wstate_nxt = W_WAIT_A;
      end
      W_WAIT_D: if (w_hs)          wstate_nxt = W_RESP;
      W_WAIT_A: if (aw_hs)         wstate_nxt = W_RESP;
      W_RESP:   if (s_axi_bready)  wstate_nxt = W_IDLE;
      default:                     wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready_nxt = (wstate_nxt == W_IDLE) || (wstate_nxt == W_WAIT_A);
    wready_nxt  = (wstate_nxt == W_IDLE) || (wstate_nxt == W_WAIT_D);
    bvalid_nxt  = (wstate_nxt == W_RESP);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      s_axi_awready <= awready_nxt;
      s_axi_wready  <= wready_nxt;
      s_axi_bvalid  <= bvalid_nxt;
    end
  end

  // The commit edge is the one on which the last missing handshake lands.
  assign commit = (wstate != W_RESP) && (wstate_nxt == W_RESP);

  // ---------------------------------------------------------------------------
  // Stage p0: hold whichever half of the write arrived first
  // ---------------------------------------------------------------------------
  logic [IW-1:0] aw_idx_p0;
  logic [31:0]   wdata_p0;
  logic [3:0]    wstrb_p0;

  always_ff @(posedge aclk) begin
    if (aw_hs)
      aw_idx_p0 <= s_axi_awaddr[ADDR_WIDTH-1:2];
    if (w_hs) begin
      wdata_p0 <= s_axi_wdata;
      wstrb_p0 <= s_axi_wstrb;
    end
  end

  logic [IW-1:0] cm_idx;
  logic [RW-1:0] cm_ri;
  logic [31:0]   cm_data;
  logic [3:0]    cm_strb;

  always_comb begin
    cm_idx  = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : aw_idx_p0;
    cm_data = w_hs  ? s_axi_wdata : wdata_p0;
    cm_strb = w_hs  ? s_axi_wstrb : wstrb_p0;
    cm_ri   = cm_idx[RW-1:0];
  end

  // ---------------------------------------------------------------------------
  // Register bank, write response and write strobes
  // ---------------------------------------------------------------------------
  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      wr_pulse    <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        s_axi_bresp <= wr_resp(cm_idx);
        if (is_ctrl(cm_idx)) begin
          for (int k = 0; k < 4; k++)
            if (cm_strb[k])
              regs[cm_ri][8*k +: 8] <= cm_data[8*k +: 8];
          // Strobe fires even with wstrb = 0: the access itself is the event.
          wr_pulse[cm_ri] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl_regs = '0;
    for (int i = 2; i < NUM_REGS; i++)
      ctrl_regs[32*i +: 32] = regs[i];
  end

  // ---------------------------------------------------------------------------
  // Read channel FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  rstate_t rstate, rstate_nxt;
  logic    ar_hs;
  logic    arready_nxt, rvalid_nxt;

  assign ar_hs = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge aclk) begin
    if (!aresetn)
      rstate <= R_IDLE;
    else
      rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs)        rstate_nxt = R_RESP;
      R_RESP:  if (s_axi_rready) rstate_nxt = R_IDLE;
      default:                   rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready_nxt = (rstate_nxt == R_IDLE);
    rvalid_nxt  = (rstate_nxt == R_RESP);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
    end else begin
      s_axi_arready <= arready_nxt;
      s_axi_rvalid  <= rvalid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data select and capture
  // ---------------------------------------------------------------------------
  logic [IW-1:0] ar_idx;
  logic [31:0]   rd_word;
  logic [1:0]    rd_code;

  always_comb begin
    ar_idx  = s_axi_araddr[ADDR_WIDTH-1:2];
    rd_word = '0;
    rd_code = RESP_OKAY;
    if (ar_idx == '0)
      rd_word = ID_VALUE;
    else if (ar_idx == IW'(1))
      rd_word = status_in;
    else if (in_range(ar_idx))
      rd_word = regs[ar_idx[RW-1:0]];
    else
      rd_code = RESP_OOR;
  end

  // Captured at the AR edge and held until rready; a same-edge write commit
  // is not visible here because regs still holds the old value.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rdata <= rd_word;
      s_axi_rresp <= rd_code;
    end
  end

endmodule

// File: tb/tb_fm_axil_reg_slave.sv
`timescale 1ns/1ps
module tb_fm_axil_reg_slave;
  localparam int AW = 12;
  localparam int NR = 16;
`ifdef FM_AXIL_DECERR_EN
  localparam logic [1:0] OOR = 2'b11;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [AW-1:0]   s_axi_awaddr = '0;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [31:0]     s_axi_wdata = '0;
  logic [3:0]      s_axi_wstrb = '0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;
  logic [AW-1:0]   s_axi_araddr = '0;
  logic            s_axi_arvalid = 1'b0;
  logic            s_axi_arready;
  logic [31:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rvalid;
  logic            s_axi_rready = 1'b0;
  logic [31:0]     status_in = '0;
  logic [32*NR-1:0] ctrl_regs;
  logic [NR-1:0]   wr_pulse;

  always #5 aclk = ~aclk;

  fm_axil_reg_slave #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .ID_VALUE(32'hF0A1_0001)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .status_in(status_in),
    .ctrl_regs(ctrl_regs), .wr_pulse(wr_pulse)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain register array plus expected strobe vector.
  logic [31:0]      mregs [NR];
  logic [NR-1:0]    exp_pulse = '0;
  logic [32*NR-1:0] img;
  bit               cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    exp_pulse = '0;
  endtask

  function automatic logic [1:0] m_wresp(input logic [AW-1:0] a);
    int idx = int'(a[AW-1:2]);
    if (idx >= NR) return OOR;
    if (idx < 2)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] m_rresp(input logic [AW-1:0] a);
    int idx = int'(a[AW-1:2]);
    return (idx >= NR) ? OOR : 2'b00;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [AW-1:0] a, input logic [31:0] st);
    int idx = int'(a[AW-1:2]);
    if (idx == 0)  return 32'hF0A1_0001;
    if (idx == 1)  return st;
    if (idx >= NR) return 32'h0;
    return mregs[idx];
  endfunction

  task automatic m_commit(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[AW-1:2]);
    if (idx >= 2 && idx < NR) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) mregs[idx][8*k +: 8] = d[8*k +: 8];
      exp_pulse = '0;
      exp_pulse[idx] = 1'b1;
    end
  endtask

  // Every-cycle comparison of the register image and write strobes.
  always @(negedge aclk) begin
    if (cmp_en) begin
      img = '0;
      for (int i = 2; i < NR; i++) img[32*i +: 32] = mregs[i];
      checks++;
      if (ctrl_regs !== img) begin
        errors++;
        $display("FAIL ctrl_regs got %h want %h", ctrl_regs, img);
      end
      chk("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
      exp_pulse = '0;
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int bhold);
    bit awp = 1'b1, wp = 1'b1, awf, wf;
    int cyc = 0;
    logic [1:0] er;
    er = m_wresp(a);
    while ((awp || wp) && cyc < 40) begin
      s_axi_awaddr  = a;
      s_axi_wdata   = d;
      s_axi_wstrb   = s;
      s_axi_awvalid = awp && (cyc >= aw_dly);
      s_axi_wvalid  = wp && (cyc >= w_dly);
      awf = s_axi_awvalid && s_axi_awready;
      wf  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (awf) awp = 1'b0;
      if (wf)  wp = 1'b0;
      if (!awp && !wp) m_commit(a, d, s);
      cyc++;
      @(negedge aclk);
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (awp || wp) begin
      checks++; errors++;
      $display("FAIL write_timeout got pending want done addr %h", a);
      return;
    end
    chk("bvalid_latency", 32'(s_axi_bvalid), 32'd1);
    chk("bresp", 32'(s_axi_bresp), 32'(er));
    for (int i = 0; i < bhold; i++) begin
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      chk("hold_awready", 32'(s_axi_awready), 32'd0);
      chk("hold_wready", 32'(s_axi_wready), 32'd0);
      @(posedge aclk); @(negedge aclk);
      chk("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("hold_bresp", 32'(s_axi_bresp), 32'(er));
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b1;
    @(posedge aclk); @(negedge aclk);
    s_axi_bready = 1'b0;
    chk("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] st, input int rhold,
                         output logic [31:0] got);
    logic [31:0] ed = '0;
    logic [1:0]  er = '0;
    int cyc = 0;
    bit done = 1'b0;
    got = 'x;
    s_axi_araddr  = a;
    status_in     = st;
    s_axi_arvalid = 1'b1;
    while (!done && cyc < 40) begin
      if (s_axi_arready) begin
        ed = m_rdata(a, st);
        er = m_rresp(a);
        done = 1'b1;
      end
      @(posedge aclk); cyc++; @(negedge aclk);
    end
    s_axi_arvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_timeout got no arready want arready addr %h", a);
      return;
    end
    chk("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
    chk("rdata", s_axi_rdata, ed);
    chk("rresp", 32'(s_axi_rresp), 32'(er));
    got = s_axi_rdata;
    for (int i = 0; i < rhold; i++) begin
      status_in = ~st;
      @(posedge aclk); @(negedge aclk);
      chk("hold_rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("hold_rdata", s_axi_rdata, ed);
    end
    status_in    = st;
    s_axi_rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    s_axi_rready = 1'b0;
    chk("rvalid_drop", 32'(s_axi_rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 m_clear();
    cmp_en = 1'b1;
    @(negedge aclk);
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    chk("rel_awready", 32'(s_axi_awready), 32'd1);
    chk("rel_wready", 32'(s_axi_wready), 32'd1);
    chk("rel_arready", 32'(s_axi_arready), 32'd1);

    // AW and W together
    do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("reg2_literal", ctrl_regs[95:64], 32'hDEADBEEF);

    // W three cycles ahead of AW, partial strobes, bready held low
    do_write(12'h00C, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(12'h00C, 32'h11223344, 4'h5, 3, 0, 4);
    chk("reg3_literal", ctrl_regs[127:96], 32'hAA22CC44);
    chk("model_reg3", mregs[3], 32'hAA22CC44);

    // ID and status reads, rready held low
    do_read(12'h000, 32'h0, 0, got);
    chk("id_literal", got, 32'hF0A10001);
    do_read(12'h004, 32'h0000BEEF, 5, got);
    chk("status_literal", got, 32'h0000BEEF);

    // Write to read-only status index
    do_write(12'h004, 32'h55555555, 4'hF, 0, 0, 0);
    chk("slverr_literal", 32'(m_wresp(12'h004)), 32'd2);
    do_read(12'h004, 32'h0000BEEF, 0, got);
    chk("status_after_wr", got, 32'h0000BEEF);

    // Out-of-range index 16
    do_write(12'h040, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(12'h040, 32'h0, 0, got);
    chk("oor_rdata_literal", got, 32'h0);

    // Zero strobes still pulse; top index with AW ahead of W; addr[1:0] ignored
    do_write(12'h010, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    do_write(12'h03C, 32'hCAFEF00D, 4'hF, 0, 2, 1);
    do_read(12'h03C, 32'h0, 0, got);
    chk("reg15_literal", got, 32'hCAFEF00D);
    do_write(12'h00B, 32'h01020304, 4'hF, 0, 0, 0);
    do_read(12'h00A, 32'h0, 2, got);
    chk("reg2_lsb_ignored", got, 32'h01020304);
    do_read(12'h00C, 32'h0, 0, got);

    // Reset while waiting for write data
    s_axi_awaddr  = 12'h008;
    s_axi_awvalid = 1'b1;
    chk("pre_awready", 32'(s_axi_awready), 32'd1);
    @(posedge aclk); @(negedge aclk);
    s_axi_awvalid = 1'b0;
    chk("waitd_awready", 32'(s_axi_awready), 32'd0);
    chk("waitd_wready", 32'(s_axi_wready), 32'd1);
    s_axi_wdata  = 32'hFFFFFFFF;
    s_axi_wstrb  = 4'hF;
    s_axi_wvalid = 1'b1;
    aresetn      = 1'b0;
    @(posedge aclk); #1 m_clear();
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
    chk("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("midrst_awready", 32'(s_axi_awready), 32'd0);
    chk("midrst_reg2", ctrl_regs[95:64], 32'h0);
    aresetn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    chk("post_awready", 32'(s_axi_awready), 32'd1);
    chk("post_bvalid", 32'(s_axi_bvalid), 32'd0);
    do_write(12'h008, 32'h13579BDF, 4'hF, 0, 0, 0);
    do_read(12'h008, 32'h0, 0, got);
    chk("post_rst_reg2", got, 32'h13579BDF);

    repeat (2) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
